// File: rtl/fft_bin_streamer.sv
// -----------------------------------------------------------------------------
// fft_bin_streamer
//
// Purpose:
//   Unloads one complete 8-bin complex frame from the FFT/IFFT core in a single
//   parallel handshake and stores it in a two-frame ping-pong buffer. The bins
//   are then streamed out in natural order 0..7, one per cycle, over a
//   valid/ready interface. Each bin is tagged with the FFT/IFFT mode of its
//   frame.
//
// Optional feature:
//   FFT_BIN_STREAMER_MAGSQ_EN - when defined, adds the out_magsq port. This
//   output is out_r^2 + out_i^2 and is registered alongside the bin, so it adds
//   no latency.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   frame_valid  in   parallel frame present on bin_r/bin_i
//   frame_ready  out  a frame can be accepted this cycle (registered state only)
//   frame_mode   in   0 = FFT result, 1 = IFFT result
//   bin_r/bin_i  in   8 packed signed components, bin k at [k*DATA_W +: DATA_W]
//   out_valid    out  output word valid
//   out_ready    in   downstream accepts word
//   out_r/out_i  out  current bin components
//   out_idx      out  bin index 0..7
//   out_last     out  high with bin 7
//   out_mode     out  mode tag of the frame the bin belongs to
//   out_magsq    out  unsigned out_r^2 + out_i^2 (optional)
// -----------------------------------------------------------------------------
module fft_bin_streamer #(
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_valid,
  output logic                frame_ready,
  input  logic                frame_mode,
  input  logic [8*DATA_W-1:0] bin_r,
  input  logic [8*DATA_W-1:0] bin_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_r,
  output logic [DATA_W-1:0]   out_i,
  output logic [2:0]          out_idx,
  output logic                out_last,
  output logic                out_mode
`ifdef FFT_BIN_STREAMER_MAGSQ_EN
  ,
  output logic [2*DATA_W:0]   out_magsq
`endif
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  // Ping-pong frame storage. Data words carry no reset; only the full flags
  // decide whether their contents are meaningful.
  logic [DATA_W-1:0] buf_r_q [2][8];
  logic [DATA_W-1:0] buf_i_q [2][8];
  logic [1:0]        buf_mode_q;

  state_t            state_q, state_d;
  logic [1:0]        full_q, full_d;
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic [2:0]        rd_idx_q, rd_idx_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_r_q, out_r_d;
  logic [DATA_W-1:0] out_i_q, out_i_d;
  logic [2:0]        out_idx_q, out_idx_d;
  logic              out_last_q, out_last_d;
  logic              out_mode_q, out_mode_d;

  logic              capture;
  logic              load;
  logic [DATA_W-1:0] word_r;
  logic [DATA_W-1:0] word_i;

`ifdef FFT_BIN_STREAMER_MAGSQ_EN
  logic [2*DATA_W:0]          magsq_q, magsq_d;
  logic signed [2*DATA_W-1:0] sq_r;
  logic signed [2*DATA_W-1:0] sq_i;
`endif

  // Ready depends only on registered state, so a buffer freed at an edge is
  // advertised starting with the following cycle.
  assign frame_ready = !reset && !full_q[wr_sel_q];
  assign capture     = frame_valid && frame_ready;
  assign load        = (state_q == S_STREAM) && (!out_valid_q || out_ready);

  assign word_r = buf_r_q[rd_sel_q][rd_idx_q];
  assign word_i = buf_i_q[rd_sel_q][rd_idx_q];

`ifdef FFT_BIN_STREAMER_MAGSQ_EN
  // Both squares are non-negative and at most 2^(2*DATA_W-2), so zero-extending
  // them and adding cannot overflow the 2*DATA_W+1 bit result.
  assign sq_r = $signed(word_r) * $signed(word_r);
  assign sq_i = $signed(word_i) * $signed(word_i);
`endif

  always_comb begin
    full_d      = full_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    rd_idx_d    = rd_idx_q;
    out_valid_d = out_valid_q;
    out_r_d     = out_r_q;
    out_i_d     = out_i_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    out_mode_d  = out_mode_q;
`ifdef FFT_BIN_STREAMER_MAGSQ_EN
    magsq_d     = magsq_q;
`endif

    // The capture and read buffers can never coincide. Capture needs
    // full[wr_sel] clear, and reading needs full[rd_sel] set.
    if (capture) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end

    if (load) begin
      out_valid_d = 1'b1;
      out_r_d     = word_r;
      out_i_d     = word_i;
      out_idx_d   = rd_idx_q;
      out_last_d  = (rd_idx_q == 3'd7);
      out_mode_d  = buf_mode_q[rd_sel_q];
`ifdef FFT_BIN_STREAMER_MAGSQ_EN
      magsq_d     = {1'b0, sq_r} + {1'b0, sq_i};
`endif
      rd_idx_d    = 3'(rd_idx_q + 3'd1);
      if (rd_idx_q == 3'd7) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
      end
    end else if (out_ready) begin
      // Only reachable in IDLE: the pending word (if any) is consumed.
      out_valid_d = 1'b0;
    end

    // The state register tracks whether the buffer to be read next is full.
    state_d = full_d[rd_sel_d] ? S_STREAM : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      full_q      <= 2'b00;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      rd_idx_q    <= 3'd0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      out_idx_q   <= 3'd0;
      out_last_q  <= 1'b0;
      out_mode_q  <= 1'b0;
`ifdef FFT_BIN_STREAMER_MAGSQ_EN
      magsq_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      rd_idx_q    <= rd_idx_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_mode_q  <= out_mode_d;
`ifdef FFT_BIN_STREAMER_MAGSQ_EN
      magsq_q     <= magsq_d;
`endif
    end
  end

  // Frame capture into the buffer selected by wr_sel.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_capture
      always_ff @(posedge clk) begin
        if (capture) begin
          buf_r_q[wr_sel_q][gi] <= bin_r[gi*DATA_W +: DATA_W];
          buf_i_q[wr_sel_q][gi] <= bin_i[gi*DATA_W +: DATA_W];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (capture) begin
      buf_mode_q[wr_sel_q] <= frame_mode;
    end
  end

  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_i     = out_i_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign out_mode  = out_mode_q;
`ifdef FFT_BIN_STREAMER_MAGSQ_EN
  assign out_magsq = magsq_q;
`endif

endmodule

// File: tb/tb_fft_bin_streamer.sv
// -----------------------------------------------------------------------------
// Testbench for fft_bin_streamer. Directed scenarios, each in its own task.
// Frame f carries bin_r[k] = f*0x1000 + k*0x0100 and bin_i[k] = -(k + 8*f).
// Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_fft_bin_streamer;
  localparam int DATA_W = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic                frame_valid;
  logic                frame_ready;
  logic                frame_mode;
  logic [8*DATA_W-1:0] bin_r;
  logic [8*DATA_W-1:0] bin_i;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_r;
  logic [DATA_W-1:0]   out_i;
  logic [2:0]          out_idx;
  logic                out_last;
  logic                out_mode;
`ifdef FFT_BIN_STREAMER_MAGSQ_EN
  logic [2*DATA_W:0]   out_magsq;
`endif

  int checks = 0;
  int errors = 0;

  logic [37:0] obs;
  assign obs = {out_valid, out_r, out_i, out_idx, out_last, out_mode};

  always #5 clk = ~clk;

  fft_bin_streamer #(.DATA_W(DATA_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_mode  (frame_mode),
    .bin_r       (bin_r),
    .bin_i       (bin_i),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_r       (out_r),
    .out_i       (out_i),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .out_mode    (out_mode)
`ifdef FFT_BIN_STREAMER_MAGSQ_EN
    ,
    .out_magsq   (out_magsq)
`endif
  );

  function automatic logic [15:0] exp_r(input int f, input int k);
    return 16'(f * 32'h1000 + k * 32'h0100);
  endfunction

  function automatic logic [15:0] exp_i(input int f, input int k);
    return 16'(-(k + 8 * f));
  endfunction

  function automatic logic [37:0] exp_word(input int f, input int k, input logic mode);
    return {1'b1, exp_r(f, k), exp_i(f, k), 3'(k), (k == 7), mode};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input int f, input logic mode);
    for (int k = 0; k < 8; k++) begin
      bin_r[k*DATA_W +: DATA_W] = exp_r(f, k);
      bin_i[k*DATA_W +: DATA_W] = exp_i(f, k);
    end
    frame_mode = mode;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (obs !== 38'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 38'd0);
    end
    checks++;
    if (frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_frame_ready: got %b expected 0", frame_ready);
    end
`ifdef FFT_BIN_STREAMER_MAGSQ_EN
    checks++;
    if (out_magsq !== '0) begin
      errors++;
      $display("FAIL reset_magsq: got %h expected 0", out_magsq);
    end
`endif
    reset = 1'b0;
    tick();
    checks++;
    if (frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_frame_ready: got %b expected 1", frame_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_frame();
    out_ready = 1'b1;
    drive_frame(0, 1'b0);
    frame_valid = 1'b1;
    checks++;
    if (frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_frame_ready: got %b expected 1", frame_ready);
    end
    tick();
    frame_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_latency: out_valid got %b expected 0 one cycle after capture", out_valid);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (obs !== exp_word(0, k, 1'b0)) begin
        errors++;
        $display("FAIL single_bin%0d: got %h expected %h", k, obs, exp_word(0, k, 1'b0));
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: out_valid got %b expected 0", out_valid);
    end
    $display("test_single_frame done");
  endtask

  task automatic test_backpressure();
    logic [3:0]  pat;
    logic [37:0] prev;
    logic        stalled;
    int          n;
    pat     = 4'b1001;
    stalled = 1'b0;
    prev    = '0;
    n       = 0;
    drive_frame(1, 1'b1);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
      if (stalled) begin
        checks++;
        if (obs !== prev) begin
          errors++;
          $display("FAIL bp_stable cyc%0d: got %h expected %h", cyc, obs, prev);
        end
      end
      out_ready = pat[cyc % 4];
      if (out_valid && out_ready) begin
        checks++;
        if (obs !== exp_word(1, n, 1'b1)) begin
          errors++;
          $display("FAIL bp_word%0d: got %h expected %h", n, obs, exp_word(1, n, 1'b1));
        end
        n++;
      end
      stalled = out_valid && !out_ready;
      prev    = obs;
      tick();
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL bp_count: got %0d words expected 8", n);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_dup: out_valid got %b expected 0", out_valid);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_three_frames();
    int   frames [3];
    logic modes  [3];
    int   n;
    logic driving;
    logic accepting;
    frames = '{2, 3, 4};
    modes  = '{1'b0, 1'b1, 1'b0};
    out_ready = 1'b0;
    drive_frame(2, 1'b0);
    frame_valid = 1'b1;
    checks++;
    if (frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL three_accept_a: frame_ready got %b expected 1", frame_ready);
    end
    tick();
    drive_frame(3, 1'b1);
    checks++;
    if (frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL three_accept_b: frame_ready got %b expected 1", frame_ready);
    end
    tick();
    drive_frame(4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (frame_ready !== 1'b0) begin
        errors++;
        $display("FAIL three_full%0d: frame_ready got %b expected 0", i, frame_ready);
      end
      checks++;
      if (obs !== exp_word(2, 0, 1'b0)) begin
        errors++;
        $display("FAIL three_hold%0d: got %h expected %h", i, obs, exp_word(2, 0, 1'b0));
      end
      tick();
    end
    out_ready = 1'b1;
    n         = 0;
    driving   = 1'b1;
    accepting = 1'b0;
    for (int cyc = 0; cyc < 60 && n < 24; cyc++) begin
      checks++;
      if (obs !== exp_word(frames[n/8], n % 8, modes[n/8])) begin
        errors++;
        $display("FAIL three_word%0d: got %h expected %h", n, obs,
                 exp_word(frames[n/8], n % 8, modes[n/8]));
      end
      n++;
      if (accepting) begin
        frame_valid = 1'b0;
        accepting   = 1'b0;
        driving     = 1'b0;
      end else if (driving) begin
        checks++;
        if (frame_ready !== (n >= 8)) begin
          errors++;
          $display("FAIL three_ready word%0d: frame_ready got %b expected %b", n - 1, frame_ready, (n >= 8));
        end
        if (frame_ready) accepting = 1'b1;
      end
      tick();
    end
    frame_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL three_drain: out_valid got %b expected 0", out_valid);
    end
    $display("test_three_frames done");
  endtask

  task automatic test_reset_midstream();
    logic found;
    found = 1'b0;
    out_ready = 1'b1;
    drive_frame(5, 1'b0);
    frame_valid = 1'b1;
    tick();
    drive_frame(6, 1'b1);
    tick();
    frame_valid = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (out_valid && out_idx == 3'd3) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midreset_bin3: bin 3 not seen, got idx %0d valid %b expected idx 3 valid 1", out_idx, out_valid);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (obs !== 38'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h expected %h", obs, 38'd0);
    end
    checks++;
    if (frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_frame_ready: got %b expected 0", frame_ready);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready_after: got %b expected 1", frame_ready);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_stale cyc%0d: out_valid got %b expected 0", i, out_valid);
      end
      tick();
    end
    $display("test_reset_midstream done");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive_frame(7, 1'b1);
    frame_valid = 1'b1;
    tick();
    drive_frame(6, 1'b0);
    checks++;
    if (frame_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_offer: ready/valid got %b/%b expected 1/0", frame_ready, out_valid);
    end
    tick();
    frame_valid = 1'b0;
    for (int n = 0; n < 16; n++) begin
      checks++;
      if (obs !== exp_word(n < 8 ? 7 : 6, n % 8, n < 8)) begin
        errors++;
        $display("FAIL b2b_word%0d: got %h expected %h", n, obs, exp_word(n < 8 ? 7 : 6, n % 8, n < 8));
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: out_valid got %b expected 0", out_valid);
    end
    $display("test_back_to_back done");
  endtask

`ifdef FFT_BIN_STREAMER_MAGSQ_EN
  task automatic test_magsq();
    out_ready = 1'b1;
    bin_r = '0;
    bin_i = '0;
    bin_r[0*DATA_W +: DATA_W] = 16'h7FFF;
    bin_i[0*DATA_W +: DATA_W] = 16'h8000;
    bin_r[1*DATA_W +: DATA_W] = 16'hFFFD;
    bin_i[1*DATA_W +: DATA_W] = 16'h0004;
    frame_mode  = 1'b0;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    tick();
    checks++;
    if (out_magsq !== 33'h07FFF0001) begin
      errors++;
      $display("FAIL magsq_extreme: got %h expected %h", out_magsq, 33'h07FFF0001);
    end
    tick();
    checks++;
    if (out_magsq !== 33'd25) begin
      errors++;
      $display("FAIL magsq_25: got %0d expected 25", out_magsq);
    end
    tick();
    checks++;
    if (out_magsq !== 33'd0) begin
      errors++;
      $display("FAIL magsq_zero: got %0d expected 0", out_magsq);
    end
    for (int i = 0; i < 7; i++) tick();
    $display("test_magsq done");
  endtask
`endif

  initial begin
    reset       = 1'b1;
    frame_valid = 1'b0;
    frame_mode  = 1'b0;
    out_ready   = 1'b0;
    bin_r       = '0;
    bin_i       = '0;
    test_reset();
    test_single_frame();
    test_backpressure();
    test_three_frames();
    test_reset_midstream();
    test_back_to_back();
`ifdef FFT_BIN_STREAMER_MAGSQ_EN
    test_magsq();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
